// File: rtl/dsp_pkg.sv
// Shared definitions for the SIMD MAC slice: configuration bit layout and
// the per-lane overflow / saturation decision helpers.
package dsp_pkg;

    // Configuration register layout (shifted in serially, MSB drives cfg_out)
    localparam int CFG_W        = 4;
    localparam int CFG_A_SIGNED = 0;
    localparam int CFG_B_SIGNED = 1;
    localparam int CFG_SATURATE = 2;
    localparam int CFG_CHAIN_EN = 3;

    // Result select for one lane of the saturating add
    typedef enum logic [1:0] {
        SEL_SUM = 2'd0,   // sum fits (or wrap mode): keep low ACC_W bits
        SEL_POS = 2'd1,   // clamp to most positive value
        SEL_NEG = 2'd2    // clamp to most negative value
    } sat_sel_e;

    // The sum is formed one bit wider than the accumulator; it is outside the
    // signed ACC_W range exactly when its top two bits disagree.
    function automatic logic ovf_test(input logic [1:0] top);
        return top[1] ^ top[0];
    endfunction

    // Chooses the lane result of base+product from the top two sum bits.
    // The extra (sign) bit tells which rail to clamp to.
    function automatic sat_sel_e sat_add(input logic [1:0] top, input logic sat);
        if (sat && ovf_test(top)) begin
            return top[1] ? SEL_NEG : SEL_POS;
        end
        return SEL_SUM;
    endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// One SIMD lane: S2 product register, S3 accumulator with saturation and
// sticky overflow, and the held output register loaded by a last beat.
module dsp_mac_lane
    import dsp_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_adv,
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic              i_a_signed,
    input  logic              i_b_signed,
    input  logic              i_s2_valid,
    input  logic              i_s2_first,
    input  logic              i_s3_valid,
    input  logic              i_s3_last,
    input  logic              i_saturate,
    input  logic              i_chain_en,
    input  logic [ACC_W-1:0]  i_pcin,
    output logic [ACC_W-1:0]  o_p,
    output logic              o_ovf
);

    localparam int PW = 2 * LANE_W + 2;
    localparam int XW = (ACC_W + 1 > PW) ? ACC_W + 1 : PW;

    logic signed [LANE_W:0] w_a_x;
    logic signed [LANE_W:0] w_b_x;
    logic signed [PW-1:0]   r_prod;
    logic signed [XW-1:0]   w_px;
    logic                   w_unused_px;
    logic [ACC_W:0]         w_prod_x;
    logic [ACC_W-1:0]       w_base;
    logic [ACC_W:0]         w_base_x;
    logic [ACC_W:0]         w_sum;
    sat_sel_e               w_sel;
    logic [ACC_W-1:0]       w_res;
    logic                   w_ovf_new;
    logic [ACC_W-1:0]       r_acc;
    logic                   r_acc_ovf;
    logic [ACC_W-1:0]       r_p;
    logic                   r_ovf;

    // Operands widened by one bit so signed and unsigned share one multiplier
    assign w_a_x = {i_a_signed & i_a[LANE_W-1], i_a};
    assign w_b_x = {i_b_signed & i_b[LANE_W-1], i_b};

    // S2: product register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prod <= '0;
        end else if (i_adv) begin
            r_prod <= w_a_x * w_b_x;
        end
    end

    // Product sign-extended (or trimmed) to the ACC_W+1 adder width
    assign w_px        = XW'(r_prod);
    assign w_prod_x    = w_px[ACC_W:0];
    assign w_unused_px = ^w_px;

    assign w_base   = i_s2_first ? (i_chain_en ? i_pcin : '0) : r_acc;
    assign w_base_x = {w_base[ACC_W-1], w_base};
    assign w_sum    = w_base_x + w_prod_x;
    assign w_sel    = sat_add(w_sum[ACC_W:ACC_W-1], i_saturate);

    // Clamp or wrap the wide sum back to ACC_W bits
    always_comb begin
        w_res = w_sum[ACC_W-1:0];
        case (w_sel)
            SEL_POS: w_res = {1'b0, {(ACC_W-1){1'b1}}};
            SEL_NEG: w_res = {1'b1, {(ACC_W-1){1'b0}}};
            default: w_res = w_sum[ACC_W-1:0];
        endcase
    end

    // Overflow is sticky within an accumulation; a first beat restarts it
    assign w_ovf_new = ovf_test(w_sum[ACC_W:ACC_W-1]) | (~i_s2_first & r_acc_ovf);

    // S3: accumulator update for every valid beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
        end else if (i_adv && i_s2_valid) begin
            r_acc     <= w_res;
            r_acc_ovf <= w_ovf_new;
        end
    end

    // Output register: captures the finished accumulation of a last beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else if (i_adv && i_s3_valid && i_s3_last) begin
            r_p   <= r_acc;
            r_ovf <= r_acc_ovf;
        end
    end

    assign o_p   = r_p;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/dsp_simd_mac_rf.sv
// SIMD multiply-accumulate slice: A-operand register file, S1 operand stage,
// valid pipeline with output backpressure, serial configuration chain and
// LANES instances of dsp_mac_lane.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. out_valid/p_data hold
// until taken, and while a result waits every stage freezes (in_ready=0).
module dsp_simd_mac_rf
    import dsp_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int LANE_W   = 8,
    parameter int ACC_W    = 24,
    parameter int RF_DEPTH = 8,
    parameter int RF_AW    = $clog2(RF_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_in,
    input  logic                      cfg_en,
    output logic                      cfg_out,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [LANES*LANE_W-1:0]   a_data,
    input  logic [LANES*LANE_W-1:0]   b_data,
    input  logic                      use_rf,
    input  logic [RF_AW-1:0]          rf_raddr,
    input  logic                      rf_load,
    input  logic [RF_AW-1:0]          rf_waddr,
    input  logic [LANES*ACC_W-1:0]    pcin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ACC_W-1:0]    p_data,
    output logic [LANES-1:0]          p_ovf,
    output logic [LANES*ACC_W-1:0]    pcout
);

    localparam int DW = LANES * LANE_W;

    logic [CFG_W-1:0]       r_cfg;
    logic [DW-1:0]          r_rf [RF_DEPTH];
    logic                   w_adv;
    logic                   w_accept;
    logic [DW-1:0]          w_a_sel;
    logic                   r_s1_valid;
    logic                   r_s1_first;
    logic                   r_s1_last;
    logic [DW-1:0]          r_s1_a;
    logic [DW-1:0]          r_s1_b;
    logic                   r_s2_valid;
    logic                   r_s2_first;
    logic                   r_s2_last;
    logic                   r_s3_valid;
    logic                   r_s3_last;
    logic                   r_out_valid;
    logic [LANES*ACC_W-1:0] w_p;
    logic [LANES-1:0]       w_ovf;

    // Configuration chain: shift left, new bit enters at bit 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg <= '0;
        end else if (cfg_en) begin
            r_cfg <= {r_cfg[CFG_W-2:0], cfg_in};
        end
    end

    assign cfg_out = r_cfg[CFG_W-1];

    // Whole pipeline moves unless a result is waiting to be taken
    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = !cfg_en && w_adv;
    assign w_accept = in_valid && in_ready;

    // A-operand register file; writes ignore the stream handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else if (rf_load) begin
            r_rf[rf_waddr] <= a_data;
        end
    end

    // Read sees the pre-write contents, so a same-edge write returns old data
    assign w_a_sel = use_rf ? r_rf[rf_raddr] : a_data;

    // S1: operand capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_accept;
            r_s1_first <= w_accept & in_first;
            r_s1_last  <= w_accept & in_last;
            r_s1_a     <= w_a_sel;
            r_s1_b     <= b_data;
        end
    end

    // Beat control alongside the S2 product and S3 accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_last;
        end
    end

    // Result valid: set when a finished accumulation leaves S3, cleared when taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s3_valid && r_s3_last;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dsp_mac_lane #(
            .LANE_W (LANE_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_adv      (w_adv),
            .i_a        (r_s1_a[g*LANE_W +: LANE_W]),
            .i_b        (r_s1_b[g*LANE_W +: LANE_W]),
            .i_a_signed (r_cfg[CFG_A_SIGNED]),
            .i_b_signed (r_cfg[CFG_B_SIGNED]),
            .i_s2_valid (r_s2_valid),
            .i_s2_first (r_s2_first),
            .i_s3_valid (r_s3_valid),
            .i_s3_last  (r_s3_last),
            .i_saturate (r_cfg[CFG_SATURATE]),
            .i_chain_en (r_cfg[CFG_CHAIN_EN]),
            .i_pcin     (pcin[g*ACC_W +: ACC_W]),
            .o_p        (w_p[g*ACC_W +: ACC_W]),
            .o_ovf      (w_ovf[g])
        );
    end

    assign out_valid = r_out_valid;
    assign p_data    = w_p;
    assign p_ovf     = w_ovf;
    assign pcout     = w_p;

endmodule

// File: tb/tb_dsp_simd_mac_rf.sv
// Bench for dsp_simd_mac_rf: a 24-bit accumulator instance and a 16-bit one
// driven by the same stream, checked against a behavioural integer model
// through expected-result queues.
module tb_dsp_simd_mac_rf;

    localparam int LANES    = 4;
    localparam int LANE_W   = 8;
    localparam int ACC_W    = 24;
    localparam int AW16     = 16;
    localparam int RF_DEPTH = 8;
    localparam int RF_AW    = 3;
    localparam int DW       = LANES * LANE_W;
    localparam int EW       = LANES * ACC_W + LANES;
    localparam int EW16     = LANES * AW16 + LANES;

    logic                    clk;
    logic                    reset_n;
    logic                    cfg_in;
    logic                    cfg_en;
    logic                    cfg_out;
    logic                    cfg_out16;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_ready16;
    logic                    in_first;
    logic                    in_last;
    logic [DW-1:0]           a_data;
    logic [DW-1:0]           b_data;
    logic                    use_rf;
    logic [RF_AW-1:0]        rf_raddr;
    logic                    rf_load;
    logic [RF_AW-1:0]        rf_waddr;
    logic [LANES*ACC_W-1:0]  pcin;
    logic [LANES*AW16-1:0]   pcin16;
    logic                    out_valid;
    logic                    out_valid16;
    logic                    out_ready;
    logic [LANES*ACC_W-1:0]  p_data;
    logic [LANES*AW16-1:0]   p_data16;
    logic [LANES-1:0]        p_ovf;
    logic [LANES-1:0]        p_ovf16;
    logic [LANES*ACC_W-1:0]  pcout;
    logic [LANES*AW16-1:0]   pcout16;

    dsp_simd_mac_rf #(
        .LANES(LANES), .LANE_W(LANE_W), .ACC_W(ACC_W), .RF_DEPTH(RF_DEPTH), .RF_AW(RF_AW)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_out(cfg_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .a_data(a_data), .b_data(b_data), .use_rf(use_rf), .rf_raddr(rf_raddr),
        .rf_load(rf_load), .rf_waddr(rf_waddr), .pcin(pcin), .out_valid(out_valid),
        .out_ready(out_ready), .p_data(p_data), .p_ovf(p_ovf), .pcout(pcout)
    );

    dsp_simd_mac_rf #(
        .LANES(LANES), .LANE_W(LANE_W), .ACC_W(AW16), .RF_DEPTH(RF_DEPTH), .RF_AW(RF_AW)
    ) u_dut16 (
        .clk(clk), .reset_n(reset_n), .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_out(cfg_out16),
        .in_valid(in_valid), .in_ready(in_ready16), .in_first(in_first), .in_last(in_last),
        .a_data(a_data), .b_data(b_data), .use_rf(use_rf), .rf_raddr(rf_raddr),
        .rf_load(rf_load), .rf_waddr(rf_waddr), .pcin(pcin16), .out_valid(out_valid16),
        .out_ready(out_ready), .p_data(p_data16), .p_ovf(p_ovf16), .pcout(pcout16)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]   exp_q[$];
    logic [EW16-1:0] exp16_q[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              n_pop = 0;

    longint          m_acc [2][LANES];
    logic            m_ovf [2][LANES];
    logic [DW-1:0]   m_rf [RF_DEPTH];
    logic [3:0]      m_cfg;
    int              m_pcin;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int wid(input int k);
        return (k == 0) ? ACC_W : AW16;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < LANES; l++) begin
                m_acc[k][l] = 0;
                m_ovf[k][l] = 1'b0;
            end
        end
        for (int i = 0; i < RF_DEPTH; i++) m_rf[i] = '0;
        m_cfg = 4'b0000;
        exp_q.delete();
        exp16_q.delete();
    endtask

    // Integer reference of one accepted beat for both accumulator widths
    task automatic model_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic first, input logic last);
        logic [EW-1:0]   e;
        logic [EW16-1:0] e16;
        logic [63:0]     t;
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < LANES; l++) begin
                logic [7:0] a8;
                logic [7:0] b8;
                longint av, bv, base, sum, hi, lo, res, span;
                logic ov;
                a8   = a[l*LANE_W +: LANE_W];
                b8   = b[l*LANE_W +: LANE_W];
                av   = m_cfg[0] ? longint'($signed(a8)) : longint'(a8);
                bv   = m_cfg[1] ? longint'($signed(b8)) : longint'(b8);
                base = first ? (m_cfg[3] ? longint'(m_pcin) : 64'sd0) : m_acc[k][l];
                sum  = base + av * bv;
                span = longint'(1) << wid(k);
                hi   = (longint'(1) << (wid(k) - 1)) - 1;
                lo   = -hi - 1;
                ov   = (sum > hi) || (sum < lo);
                res  = sum;
                if (ov) begin
                    if (m_cfg[2]) begin
                        res = (sum > hi) ? hi : lo;
                    end else begin
                        res = sum & (span - 1);
                        if (res > hi) res = res - span;
                    end
                end
                m_acc[k][l] = res;
                m_ovf[k][l] = ov | (!first & m_ovf[k][l]);
            end
        end
        if (last) begin
            e   = '0;
            e16 = '0;
            for (int l = 0; l < LANES; l++) begin
                t = m_acc[0][l];
                e[l*ACC_W +: ACC_W] = t[ACC_W-1:0];
                e[LANES*ACC_W + l]  = m_ovf[0][l];
                t = m_acc[1][l];
                e16[l*AW16 +: AW16] = t[AW16-1:0];
                e16[LANES*AW16 + l] = m_ovf[1][l];
            end
            exp_q.push_back(e);
            exp16_q.push_back(e16);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic first, input logic last,
                             input logic urf, input logic [RF_AW-1:0] raddr,
                             input logic ld, input logic [RF_AW-1:0] waddr);
        int guard;
        logic [DW-1:0] a_eff;
        @(negedge clk);
        a_data   = a;
        b_data   = b;
        in_first = first;
        in_last  = last;
        use_rf   = urf;
        rf_raddr = raddr;
        rf_load  = ld;
        rf_waddr = waddr;
        in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            rf_load  = 1'b0;
            return;
        end
        a_eff = urf ? m_rf[raddr] : a;
        model_beat(a_eff, b, first, last);
        if (ld) m_rf[waddr] = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rf_load  = 1'b0;
    endtask

    task automatic rf_write(input logic [RF_AW-1:0] addr, input logic [DW-1:0] d);
        @(negedge clk);
        a_data   = d;
        rf_waddr = addr;
        rf_load  = 1'b1;
        m_rf[addr] = d;
        @(posedge clk);
        #1;
        rf_load = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_cfg(input logic [3:0] v);
        drain();
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            cfg_en = 1'b1;
            cfg_in = v[i];
            if (i == 0) begin
                #1;
                check_eq("in_ready_cfg", in_ready, 0);
            end
        end
        @(negedge clk);
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        m_cfg  = v;
        #1;
        check_eq("cfg_out", cfg_out, v[3]);
    endtask

    task automatic set_pcin(input int v);
        logic [31:0] vv;
        vv     = v;
        m_pcin = v;
        pcin   = {LANES{vv[ACC_W-1:0]}};
        pcin16 = {LANES{vv[AW16-1:0]}};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_p_data"}, {p_ovf, p_data}, 0);
        check_eq({tag, "_cfg_out"}, {cfg_out16, cfg_out}, 0);
        check_eq({tag, "_in_ready"}, {in_ready16, in_ready}, 2'b11);
    endtask

    // ---------------- output monitor ----------------
    always begin
        logic [EW-1:0]   e_pop;
        logic [EW16-1:0] e16_pop;
        @(negedge clk);
        #1;
        if (reset_n) begin
            if (out_valid && !out_ready) check_eq("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_result", out_valid, 0);
                end else begin
                    e_pop   = exp_q.pop_front();
                    e16_pop = exp16_q.pop_front();
                    check_eq("valid16", out_valid16, 1);
                    check_eq("p24", {p_ovf, p_data}, e_pop);
                    check_eq("pcout24", pcout, e_pop[LANES*ACC_W-1:0]);
                    check_eq("p16", {p_ovf16, p_data16}, e16_pop);
                    check_eq("pcout16", pcout16, e16_pop[LANES*AW16-1:0]);
                    n_pop++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        int            pop0;
        int            t_last;

        reset_n   = 1'b0;
        cfg_in    = 1'b0;
        cfg_en    = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        a_data    = '0;
        b_data    = '0;
        use_rf    = 1'b0;
        rf_raddr  = '0;
        rf_load   = 1'b0;
        rf_waddr  = '0;
        out_ready = 1'b1;
        model_clear();
        set_pcin(0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset_state("por");

        // Reset while beats are in flight
        shift_cfg(4'b1111);
        rf_write(3'd3, 32'h5555_5555);
        send_beat(32'h1111_1111, 32'h0202_0202, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        send_beat(32'h2222_2222, 32'h0303_0303, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset_state("mid");
        repeat (5) @(negedge clk);
        #1;
        check_eq("no_ghost_result", out_valid, 0);
        // RF must have been cleared by the reset
        send_beat(32'hFFFF_FFFF, 32'h0101_0101, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
        drain();

        // Signed dot product over three beats, with latency check
        shift_cfg(4'b0011);
        send_beat({4{8'hFD}}, {4{8'h05}}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        send_beat({4{8'hFD}}, {4{8'h05}}, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        send_beat({4{8'hFD}}, {4{8'h05}}, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        t_last = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("latency_early", out_valid, 0);
        @(posedge clk);
        #1;
        check_eq("latency_due", out_valid, 1);
        drain();

        // Register file and read-before-write
        rf_write(3'd2, {4{8'h7F}});
        send_beat('0, {4{8'h02}}, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0);
        send_beat({4{8'h01}}, {4{8'h02}}, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 3'd2);
        send_beat('0, {4{8'h02}}, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0);
        drain();

        // Saturation and wrap (observed on the 16-bit instance)
        shift_cfg(4'b0100);
        for (int i = 0; i < 3; i++)
            send_beat({4{8'h7F}}, {4{8'h7F}}, i == 0, i == 2, 1'b0, 3'd0, 1'b0, 3'd0);
        shift_cfg(4'b0000);
        for (int i = 0; i < 3; i++)
            send_beat({4{8'h7F}}, {4{8'h7F}}, i == 0, i == 2, 1'b0, 3'd0, 1'b0, 3'd0);
        shift_cfg(4'b0111);
        for (int i = 0; i < 3; i++)
            send_beat({4{8'h80}}, {4{8'h7F}}, i == 0, i == 2, 1'b0, 3'd0, 1'b0, 3'd0);
        // Overflow flag clears on the next first beat
        send_beat({4{8'h01}}, {4{8'h01}}, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);

        // Backpressure: random single-beat ops with the sink stalled
        shift_cfg(4'b0000);
        pop0 = n_pop;
        fork
            begin
                out_ready = 1'b0;
                repeat (10) @(negedge clk);
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    for (int l = 0; l < LANES; l++) begin
                        ra[l*LANE_W +: LANE_W] = 8'($urandom_range(0, 255));
                        rb[l*LANE_W +: LANE_W] = 8'($urandom_range(0, 255));
                    end
                    send_beat(ra, rb, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
                end
            end
        join
        drain();
        check_eq("bp_result_count", n_pop - pop0, 8);

        // Cascade input on first beat
        shift_cfg(4'b1000);
        set_pcin(1000);
        send_beat({4{8'h0A}}, {4{8'h0A}}, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        shift_cfg(4'b0000);
        send_beat({4{8'h0A}}, {4{8'h0A}}, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        drain();

        check_eq("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
